// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU and memory-mode codes, FSM states and the
// decoded control-flag bundle used by the decode stage and its pipeline register.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLEZ  = 6'd6;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_SRL     = 6'd2;
    localparam logic [5:0] FN_SRA     = 6'd3;
    localparam logic [5:0] FN_SLLV    = 6'd4;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_ADDU    = 6'd33;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_XOR     = 6'd38;
    localparam logic [5:0] FN_NOR     = 6'd39;
    localparam logic [5:0] FN_SLT     = 6'd42;
    localparam logic [5:0] FN_SLTU    = 6'd43;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;
    localparam logic [3:0] ALU_NONE = 4'd13;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic alu_src;
        logic regwrite;
        logic signedext;
        logic beq;
        logic bne;
        logic bgtz;
        logic blez;
        logic jr;
        logic jmp;
        logic jal;
        logic shift;
        logic syscall;
        logic illegal;
    } ctrl_flags_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: turns a 32-bit MIPS word into the
// control word registered by pipe_ctrl, plus the register fields needed for hazards.
module ctrl_decode
    import mips_pkg::*;
#(
    parameter int ALU_OP_W = 4
)
(
    input  logic [31:0]         instr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          mode,
    output logic [4:0]          dst,
    output ctrl_flags_t         flags,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic                reads_rt
);

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rd;
    logic [3:0] alu;
    logic       legal;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign func         = instr[5:0];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        alu   = ALU_NONE;
        mode  = MODE_WORD;
        dst   = rt;
        flags = '0;
        legal = 1'b1;
        if (op == OP_RTYPE) begin
            dst = rd;
            case (func)
                FN_SLL:          begin alu = ALU_SLL;  flags.regwrite = 1'b1; end
                FN_SRL:          begin alu = ALU_SRL;  flags.regwrite = 1'b1; end
                FN_SRA:          begin alu = ALU_SRA;  flags.regwrite = 1'b1; end
                FN_SLLV:         begin alu = ALU_SLL;  flags.regwrite = 1'b1; flags.shift = 1'b1; end
                FN_JR:           begin flags.jr = 1'b1; flags.jmp = 1'b1; end
                FN_SYSCALL:      flags.syscall = 1'b1;
                FN_ADD, FN_ADDU: begin alu = ALU_ADD;  flags.regwrite = 1'b1; end
                FN_SUB:          begin alu = ALU_SUB;  flags.regwrite = 1'b1; end
                FN_AND:          begin alu = ALU_AND;  flags.regwrite = 1'b1; end
                FN_OR:           begin alu = ALU_OR;   flags.regwrite = 1'b1; end
                FN_XOR:          begin alu = ALU_XOR;  flags.regwrite = 1'b1; end
                FN_NOR:          begin alu = ALU_NOR;  flags.regwrite = 1'b1; end
                FN_SLT:          begin alu = ALU_SLT;  flags.regwrite = 1'b1; end
                FN_SLTU:         begin alu = ALU_SLTU; flags.regwrite = 1'b1; end
                default:         legal = 1'b0;
            endcase
        end else begin
            case (op)
                OP_J:    flags.jmp = 1'b1;
                OP_JAL: begin
                    flags.jmp      = 1'b1;
                    flags.jal      = 1'b1;
                    flags.regwrite = 1'b1;
                    dst            = 5'd31;
                end
                OP_BEQ:  flags.beq  = 1'b1;
                OP_BNE:  flags.bne  = 1'b1;
                OP_BLEZ: flags.blez = 1'b1;
                OP_BGTZ: flags.bgtz = 1'b1;
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                    alu             = (op == OP_SLTI)  ? ALU_SLT  :
                                      (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
                    flags.regwrite  = 1'b1;
                    flags.alu_src   = 1'b1;
                    flags.signedext = 1'b1;
                end
                OP_ANDI, OP_ORI, OP_XORI: begin
                    alu            = (op == OP_ANDI) ? ALU_AND :
                                     (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                    flags.regwrite = 1'b1;
                    flags.alu_src  = 1'b1;
                end
                OP_LW: begin
                    alu             = ALU_ADD;
                    flags.regwrite  = 1'b1;
                    flags.memtoreg  = 1'b1;
                    flags.alu_src   = 1'b1;
                    flags.signedext = 1'b1;
                end
                OP_SB, OP_SH, OP_SW: begin
                    alu             = ALU_ADD;
                    flags.memwrite  = 1'b1;
                    flags.alu_src   = 1'b1;
                    flags.signedext = 1'b1;
                    mode            = (op == OP_SB) ? MODE_BYTE :
                                      (op == OP_SH) ? MODE_HALF : MODE_WORD;
                end
                default: legal = 1'b0;
            endcase
        end
        // Unknown encodings carry only the illegal flag so nothing downstream acts on them.
        if (!legal) begin
            alu           = '0;
            mode          = 2'b00;
            dst           = rt;
            flags         = '0;
            flags.illegal = 1'b1;
        end
    end

    assign alu_op   = ALU_OP_W'(alu);
    assign reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                      (op == OP_SB) || (op == OP_SH) || (op == OP_SW);

endmodule

// File: rtl/pipe_ctrl.sv
// Decode pipeline stage: registers the decoded control word, injects bubbles on
// load-use hazards, honours stall/flush, and halts on SYSCALL until resume.
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic                resume,
    output logic                valid_out,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          mode,
    output logic [4:0]          dst,
    output logic                memtoreg,
    output logic                memwrite,
    output logic                alu_src,
    output logic                regwrite,
    output logic                signedext,
    output logic                beq,
    output logic                bne,
    output logic                bgtz,
    output logic                blez,
    output logic                jr,
    output logic                jmp,
    output logic                jal,
    output logic                shift,
    output logic                syscall,
    output logic                illegal,
    output logic                halted,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic [ALU_OP_W-1:0] dec_alu_op;
    logic [1:0]          dec_mode;
    logic [4:0]          dec_dst;
    ctrl_flags_t         dec_flags;
    logic [4:0]          dec_rs;
    logic [4:0]          dec_rt;
    logic                dec_reads_rt;

    ctrl_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
        .instr    (instr),
        .alu_op   (dec_alu_op),
        .mode     (dec_mode),
        .dst      (dec_dst),
        .flags    (dec_flags),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .reads_rt (dec_reads_rt)
    );

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [1:0]          mode_q, mode_d;
    logic [4:0]          dst_q, dst_d;
    ctrl_flags_t         flags_q, flags_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic hazard;
    logic accept;

    // Load-use: the registered word is a load whose target the incoming word reads.
    assign hazard = valid_in && valid_q && flags_q.memtoreg && (dst_q != 5'd0) &&
                    ((dst_q == dec_rs) || ((dst_q == dec_rt) && dec_reads_rt));

    assign ready_out = !rst && (state_q == ST_RUN) && !stall_in && !hazard && !flush_in;
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        alu_op_d = alu_op_q;
        mode_d   = mode_q;
        dst_d    = dst_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;

        if (flush_in || !stall_in) begin
            valid_d  = 1'b0;
            alu_op_d = '0;
            mode_d   = '0;
            dst_d    = '0;
            flags_d  = '0;
            if (accept) begin
                valid_d  = 1'b1;
                alu_op_d = dec_alu_op;
                mode_d   = dec_mode;
                dst_d    = dec_dst;
                flags_d  = dec_flags;
            end
        end

        if (accept && dec_flags.syscall) begin
            state_d = ST_HALT;
        end else if ((state_q == ST_HALT) && resume) begin
            state_d = ST_RUN;
        end

        if (!flush_in && !stall_in && hazard && (state_q == ST_RUN) &&
            (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            alu_op_q <= '0;
            mode_q   <= '0;
            dst_q    <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            alu_op_q <= alu_op_d;
            mode_q   <= mode_d;
            dst_q    <= dst_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_out  = valid_q;
    assign alu_op     = alu_op_q;
    assign mode       = mode_q;
    assign dst        = dst_q;
    assign memtoreg   = flags_q.memtoreg;
    assign memwrite   = flags_q.memwrite;
    assign alu_src    = flags_q.alu_src;
    assign regwrite   = flags_q.regwrite;
    assign signedext  = flags_q.signedext;
    assign beq        = flags_q.beq;
    assign bne        = flags_q.bne;
    assign bgtz       = flags_q.bgtz;
    assign blez       = flags_q.blez;
    assign jr         = flags_q.jr;
    assign jmp        = flags_q.jmp;
    assign jal        = flags_q.jal;
    assign shift      = flags_q.shift;
    assign syscall    = flags_q.syscall;
    assign illegal    = flags_q.illegal;
    assign halted     = (state_q == ST_HALT);
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked against
// a table-driven instruction model and a cycle-level stage model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall_in, flush_in, resume;
    logic [31:0] instr;
    logic        ready_out, valid_out;
    logic [3:0]  alu_op;
    logic [1:0]  mode;
    logic [4:0]  dst;
    logic        memtoreg, memwrite, alu_src, regwrite, signedext;
    logic        beq, bne, bgtz, blez, jr, jmp, jal, shift, syscall, illegal;
    logic        halted;
    logic [15:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.ALU_OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .valid_in(valid_in), .ready_out(ready_out),
        .stall_in(stall_in), .flush_in(flush_in), .resume(resume), .valid_out(valid_out),
        .alu_op(alu_op), .mode(mode), .dst(dst), .memtoreg(memtoreg), .memwrite(memwrite),
        .alu_src(alu_src), .regwrite(regwrite), .signedext(signedext), .beq(beq), .bne(bne),
        .bgtz(bgtz), .blez(blez), .jr(jr), .jmp(jmp), .jal(jal), .shift(shift),
        .syscall(syscall), .illegal(illegal), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    int total = 0;
    int bad   = 0;
    int steps = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction table: op, funct (-1 = any), ALU code, mode, dst source
    // (0 = rd, 1 = r31, 2 = rt) and a letter set of asserted control flags.
    string t_nm[40];
    int    t_op[40], t_fn[40], t_alu[40], t_md[40], t_ds[40];
    string t_fl[40];
    int    n_ent = 0;
    int    lw_idx = 0;

    task automatic add(input string nm, input int op, input int fn, input int alu,
                       input int md, input int ds, input string fl);
        t_nm[n_ent] = nm; t_op[n_ent] = op; t_fn[n_ent] = fn; t_alu[n_ent] = alu;
        t_md[n_ent] = md; t_ds[n_ent] = ds; t_fl[n_ent] = fl;
        if (nm == "LW") lw_idx = n_ent;
        n_ent++;
    endtask

    function automatic int find(input logic [31:0] ins);
        for (int i = 0; i < n_ent; i++)
            if (t_op[i] == int'(ins[31:26]) && (t_fn[i] < 0 || t_fn[i] == int'(ins[5:0])))
                return i;
        return -1;
    endfunction

    function automatic bit has(input string s, input byte c);
        for (int i = 0; i < s.len(); i++)
            if (s[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Word layout: {valid, alu_op[3:0], mode[1:0], dst[4:0], 15 flags}; flag bit 14 is
    // memtoreg, bit 1 syscall, bit 0 illegal.
    function automatic logic [26:0] expect_word(input logic [31:0] ins);
        int          k;
        string       f;
        logic [4:0]  d;
        logic [14:0] fl;
        logic [3:0]  a;
        logic [1:0]  md;
        k = find(ins);
        if (k < 0) return {1'b1, 4'd0, 2'd0, ins[20:16], 15'd1};
        f  = t_fl[k];
        a  = 4'(t_alu[k]);
        md = 2'(t_md[k]);
        d  = (t_ds[k] == 0) ? ins[15:11] : (t_ds[k] == 1) ? 5'd31 : ins[20:16];
        fl = {has(f, "m"), has(f, "w"), has(f, "a"), has(f, "r"), has(f, "s"),
              has(f, "q"), has(f, "n"), has(f, "g"), has(f, "l"), has(f, "J"),
              has(f, "j"), has(f, "k"), has(f, "h"), has(f, "y"), 1'b0};
        return {1'b1, a, md, d, fl};
    endfunction

    function automatic bit rt_reader(input logic [5:0] op);
        return (op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd40 || op == 6'd41 || op == 6'd43);
    endfunction

    logic [26:0] m_word = '0;
    bit          m_halt = 1'b0;
    int          m_cnt  = 0;

    function automatic logic [26:0] dut_word();
        return {valid_out, alu_op, mode, dst, memtoreg, memwrite, alu_src, regwrite,
                signedext, beq, bne, bgtz, blez, jr, jmp, jal, shift, syscall, illegal};
    endfunction

    // One clock: drive inputs, check ready_out, advance the model, check outputs.
    task automatic step(input logic r, input logic [31:0] ins, input logic v,
                        input logic st, input logic fl, input logic rs_in);
        logic [26:0] nw;
        bit          hz, rdy, nh;
        int          nc;
        logic [4:0]  md;
        rst = r; instr = ins; valid_in = v; stall_in = st; flush_in = fl; resume = rs_in;
        #1;
        md  = m_word[19:15];
        hz  = v && m_word[26] && m_word[14] && (md != 5'd0) &&
              ((md == ins[25:21]) || ((md == ins[20:16]) && rt_reader(ins[31:26])));
        rdy = !r && !m_halt && !st && !hz && !fl;
        check("ready", ready_out, rdy);
        if (r) begin
            nw = '0; nh = 1'b0; nc = 0;
        end else begin
            nw = m_word; nh = m_halt; nc = m_cnt;
            if (fl) begin
                nw = '0;
            end else if (!st) begin
                if (v && rdy) begin
                    nw = expect_word(ins);
                    if (nw[1]) nh = 1'b1;
                end else begin
                    nw = '0;
                    if (hz && !m_halt && nc < 65535) nc++;
                end
            end
            if (m_halt && rs_in) nh = 1'b0;
        end
        @(posedge clk);
        #1;
        m_word = nw; m_halt = nh; m_cnt = nc;
        steps++;
        $display("cyc %0d rst=%0b ins=%08h v=%0b st=%0b fl=%0b res=%0b rdy=%0b out=%07h halt=%0b bub=%0d",
                 steps, r, ins, v, st, fl, rs_in, ready_out, dut_word(), halted, bubble_cnt);
        check("word", dut_word(), m_word);
        check("halted", halted, m_halt);
        check("bubble_cnt", bubble_cnt, m_cnt);
    endtask

    function automatic logic [31:0] rand_instr();
        int         p, k;
        logic [4:0] a, b, c;
        p = $urandom_range(0, 99);
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        if (p < 6) return $urandom();
        if (p < 10) return {6'd63, a, b, 16'($urandom())};
        if (p < 30) k = lw_idx;
        else k = $urandom_range(0, n_ent - 1);
        if (t_op[k] == 0) return {6'd0, a, b, c, 5'($urandom()), 6'(t_fn[k])};
        return {6'(t_op[k]), a, b, 16'($urandom())};
    endfunction

    initial begin
        add("SLL", 0, 0, 0, 2, 0, "r");      add("SRL", 0, 2, 2, 2, 0, "r");
        add("SRA", 0, 3, 1, 2, 0, "r");      add("SLLV", 0, 4, 0, 2, 0, "rh");
        add("JR", 0, 8, 13, 2, 0, "Jj");     add("SYSCALL", 0, 12, 13, 2, 0, "y");
        add("ADD", 0, 32, 5, 2, 0, "r");     add("ADDU", 0, 33, 5, 2, 0, "r");
        add("SUB", 0, 34, 6, 2, 0, "r");     add("AND", 0, 36, 7, 2, 0, "r");
        add("OR", 0, 37, 8, 2, 0, "r");      add("XOR", 0, 38, 9, 2, 0, "r");
        add("NOR", 0, 39, 10, 2, 0, "r");    add("SLT", 0, 42, 11, 2, 0, "r");
        add("SLTU", 0, 43, 12, 2, 0, "r");
        add("J", 2, -1, 13, 2, 2, "j");      add("JAL", 3, -1, 13, 2, 1, "jkr");
        add("BEQ", 4, -1, 13, 2, 2, "q");    add("BNE", 5, -1, 13, 2, 2, "n");
        add("BLEZ", 6, -1, 13, 2, 2, "l");   add("BGTZ", 7, -1, 13, 2, 2, "g");
        add("ADDI", 8, -1, 5, 2, 2, "ras");  add("ADDIU", 9, -1, 5, 2, 2, "ras");
        add("SLTI", 10, -1, 11, 2, 2, "ras"); add("SLTIU", 11, -1, 12, 2, 2, "ras");
        add("ANDI", 12, -1, 7, 2, 2, "ra");  add("ORI", 13, -1, 8, 2, 2, "ra");
        add("XORI", 14, -1, 9, 2, 2, "ra");  add("LW", 35, -1, 5, 2, 2, "rasm");
        add("SB", 40, -1, 5, 0, 2, "was");   add("SH", 41, -1, 5, 1, 2, "was");
        add("SW", 43, -1, 5, 2, 2, "was");

        rst = 1'b1; instr = '0; valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0; resume = 1'b0;
        @(posedge clk);
        #1;
        step(1, 32'h0, 0, 0, 0, 0);
        step(1, 32'h0, 1, 0, 0, 1);
        check("rst_valid", valid_out, 0);
        check("rst_cnt", bubble_cnt, 0);

        // ADD $3,$1,$2
        step(0, 32'h00221820, 1, 0, 0, 0);
        check("add_valid", valid_out, 1);
        check("add_alu", alu_op, 5);
        check("add_rw", regwrite, 1);
        check("add_dst", dst, 3);
        check("add_src", alu_src, 0);

        // LW $5,0($1) then ADD $6,$5,$2: one hazard bubble
        step(0, 32'h8C250000, 1, 0, 0, 0);
        check("lw_mtr", memtoreg, 1);
        step(0, 32'h00A23020, 1, 0, 0, 0);
        check("hz_valid", valid_out, 0);
        check("hz_cnt", bubble_cnt, 1);
        step(0, 32'h00A23020, 1, 0, 0, 0);
        check("hz_add_dst", dst, 6);

        // SYSCALL halts until resume
        step(0, 32'h0000000C, 1, 0, 0, 0);
        check("sys_flag", syscall, 1);
        check("sys_rw", regwrite, 0);
        check("sys_halt", halted, 1);
        step(0, 32'h00221820, 1, 0, 0, 0);
        step(0, 32'h00221820, 1, 0, 1, 0);
        check("flush_keeps_halt", halted, 1);
        step(0, 32'h00221820, 1, 0, 0, 1);
        check("resumed", halted, 0);
        step(0, 32'h00221820, 1, 0, 0, 0);
        check("run_valid", valid_out, 1);

        // SB held by stall, then flush overrides stall
        step(0, 32'hA0220004, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h00221820, 1, 1, 0, 0);
            check("sb_mode", mode, 0);
            check("sb_memwrite", memwrite, 1);
        end
        step(0, 32'h00221820, 1, 1, 1, 0);
        check("flush_valid", valid_out, 0);

        // op=63 is illegal
        step(0, 32'hFC221234, 1, 0, 0, 0);
        check("ill_flag", illegal, 1);
        check("ill_valid", valid_out, 1);
        check("ill_rw", regwrite, 0);

        // Reset while halted
        step(0, 32'h0000000C, 1, 0, 0, 0);
        check("sys2_halt", halted, 1);
        step(1, 32'h0, 0, 0, 0, 0);
        check("rh_halt", halted, 0);
        check("rh_cnt", bubble_cnt, 0);
        check("rh_valid", valid_out, 0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 1), rand_instr(), ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, meaning ALU operation code width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning bubble/stall counter width.
REQ-003 SHALL have ports `clk` (in, 1, rising-edge clock) and `rst` (in, 1, synchronous active-high reset), listed first.
REQ-004 SHALL have ports `instr` (in, 32, fetched instruction) and `valid_in` (in, 1, instr valid); `ready_out` (out, 1) SHALL mean the stage accepts instr.
REQ-005 SHALL have ports `stall_in` (in, 1, downstream hold), `flush_in` (in, 1, discard registered word) and `resume` (in, 1, leave HALT).
REQ-006 SHALL have output `valid_out` (1, registered word valid).
REQ-007 SHALL have registered outputs `alu_op` (ALU_OP_W), `mode` (2) and `dst` (5, write register).
REQ-008 SHALL have registered 1-bit outputs memtoreg, memwrite, alu_src, regwrite, signedext, beq, bne, bgtz, blez, jr, jmp, jal, shift, syscall and illegal.
REQ-009 SHALL have outputs `halted` (1, FSM in HALT) and `bubble_cnt` (CNT_W, count of injected bubbles).

Function
REQ-010 SHALL accept an instruction when valid_in && ready_out; ready_out = (state==RUN) && !stall_in && !hazard && !flush_in.
REQ-011 SHALL decode op=instr[31:26], func=instr[5:0], rs=[25:21], rt=[20:16], rd=[15:11] combinationally and register the result with 1-cycle latency.
REQ-012 SHALL select alu_op with this priority: ADD/ADDU/ADDI/ADDIU/LW/SW/SH/SB=5; SLL/SLLV=0; SRA=1; SRL=2; SUB=6; AND/ANDI=7; OR/ORI=8; XOR/XORI=9; NOR=10; SLT/SLTI=11; SLTU/SLTIU=12; otherwise 13.
REQ-013 SHALL recognise opcodes J=2, JAL=3, BEQ=4, BNE=5, BLEZ=6, BGTZ=7, ADDI=8, ADDIU=9, SLTI=10, SLTIU=11, ANDI=12, ORI=13, XORI=14, LW=35, SB=40, SH=41, SW=43.
REQ-014 SHALL recognise functs, for op 0, SLL=0, SRL=2, SRA=3, SLLV=4, JR=8, SYSCALL=12, ADD=32, ADDU=33, SUB=34, AND=36, OR=37, XOR=38, NOR=39, SLT=42, SLTU=43.
REQ-015 SHALL set regwrite for R-type excluding JR and SYSCALL, plus JAL, immediate-ALU ops and LW.
REQ-016 SHALL set memtoreg=LW; memwrite=SW|SH|SB; alu_src=immediate-ALU ops|loads|stores.
REQ-017 SHALL set signedext=ADDI|ADDIU|SLTI|SLTIU|LW|SW|SH|SB; jmp=J|JAL|JR; shift=SLLV.
REQ-018 SHALL set mode=01 for SH, 00 for SB, else 10.
REQ-019 SHALL set dst to rd for R-type, 31 for JAL, else rt.
REQ-020 SHALL set illegal=1 with all other control bits 0 for any unlisted op/funct.
REQ-021 SHALL assert hazard when valid_in && valid_out && memtoreg && dst!=0 && (dst==rs || (dst==rt && instr reads rt: R-type, BEQ, BNE, stores)).
REQ-022 SHALL, on a non-stalled edge without acceptance, load a bubble: valid_out=0, all control outputs 0, dst=0.
REQ-023 SHALL hold all registered outputs unchanged while stall_in=1 and flush_in=0.
REQ-024 SHALL give flush_in priority over stall_in and acceptance: next edge loads a bubble; flush does not leave HALT.
REQ-025 SHALL have FSM states RUN and HALT; RUN->HALT on accepting SYSCALL; HALT->RUN on resume; resume in RUN is ignored; halted = (state==HALT).
REQ-026 SHALL increment bubble_cnt by 1 on each edge where a bubble is loaded due to hazard, saturating at 2^CNT_W-1.

Reset
REQ-027 SHALL, on rst at a clock edge, set state=RUN, valid_out=0, all control outputs 0, dst=0, bubble_cnt=0.
REQ-028 SHALL give rst priority over flush_in, stall_in and resume; ready_out SHALL be 0 during reset.

Structure
REQ-029 SHALL place opcode/funct constants, ALU_OP codes, mode codes and FSM state encoding in shared package mips_pkg.
REQ-030 SHALL use one combinational sub-module, ctrl_decode (instr -> control word), feeding the pipeline register/FSM in pipe_ctrl.

Verification
REQ-031 SHALL cover ADD $3,$1,$2 (0x00221820): next cycle valid_out=1, alu_op=5, regwrite=1, dst=3, alu_src=0.
REQ-032 SHALL cover LW $5,0($1) then ADD $6,$5,$2: one bubble, ready_out=0 for one cycle, bubble_cnt=1, then ADD issues.
REQ-033 SHALL cover SYSCALL (0x0000000C): syscall=1, regwrite=0, halted=1, ready_out=0 until resume, then RUN next cycle.
REQ-034 SHALL cover stall_in=1 for 3 cycles with SB held: outputs stable, mode=00; with flush_in=1 asserted simultaneously, a bubble loads instead.
REQ-035 SHALL cover op=63: illegal=1, valid_out=1, all other controls 0.
REQ-036 SHALL cover rst asserted while halted: state=RUN, bubble_cnt=0, valid_out=0 next cycle.
